// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor and its 1-bit cell.
package addsub_pkg;

    // FSM state encoding (plain constants so legacy tools can consume them)
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Operation select
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Result of one bit slice: sum/difference bit and carry/borrow out
    typedef struct packed {
        logic s;
        logic cout;
    } bit_res_t;

    // One full add/sub step. For subtraction cin/cout are borrows, not carries.
    function automatic bit_res_t addsub_step(input logic x, input logic y,
                                             input logic cin, input logic mode);
        bit_res_t r;
        logic     p;
        p   = x ^ y;
        r.s = p ^ cin;
        if (mode == MODE_SUB) begin
            r.cout = (~x & y) | (cin & ~p);
        end else begin
            r.cout = (x & y) | (cin & p);
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_bit.sv
// Combinational 1-bit full adder/subtractor cell.
// mode=0: s = x+y+cin, cout = carry. mode=1: s = x-y-cin, cout = borrow.
module addsub_bit
    import addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    bit_res_t res;

    // Evaluate the single bit slice
    always_comb begin
        res  = addsub_step(x, y, cin, mode);
        s    = res.s;
        cout = res.cout;
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// addsub_bit cell and a carry/borrow flip-flop. WIDTH+1 cycles from start to done.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             mode_q, mode_d;
    logic             c_q, c_d;
    logic             cb_q, cb_d;

    logic             bit_s;
    logic             bit_cout;
    logic [WIDTH-1:0] res_next;

    // The only arithmetic in the datapath: operates on the current LSBs
    addsub_bit u_bit (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .cin  (c_q),
        .mode (mode_q),
        .s    (bit_s),
        .cout (bit_cout)
    );

    // Result bits enter at the MSB so the word is aligned after WIDTH shifts
    always_comb begin
        res_next = {bit_s, res_sh_q[WIDTH-1:1]};
    end

    // Next-state logic for FSM, counter, shift registers and visible outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        mode_d   = mode_q;
        c_d      = c_q;
        cb_d     = cb_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                // A start in DONE is treated exactly like one in IDLE
                if (start) begin
                    state_d  = S_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    mode_d   = mode;
                    cnt_d    = '0;
                    c_d      = 1'b0;
                    res_sh_d = '0;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next;
                c_d      = bit_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    // Visible outputs change only here, never mid-operation
                    result_d = res_next;
                    cb_d     = bit_cout;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; async reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            mode_q   <= MODE_ADD;
            c_q      <= 1'b0;
            cb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            mode_q   <= mode_d;
            c_q      <= c_d;
            cb_q     <= cb_d;
        end
    end

    // Status and result outputs decoded straight from registers
    always_comb begin
        busy         = (state_q == S_RUN);
        done         = (state_q == S_DONE);
        result       = result_q;
        carry_borrow = cb_q;
    end

endmodule
